// File: rtl/mgmt_bus_initiator.sv
// Management register bus initiator: turns the QSPI byte stream into register reads/writes.
// Frame = 16-bit header {rw, addr[14:0]} followed by data bytes at an auto-incrementing address.
module mgmt_bus_initiator #(
   parameter int READ_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   input  logic        rd_valid,
   input  logic [7:0]  rd_data,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        rd_timeout,
   output logic        busy
);

   // state    | meaning
   // IDLE     | out of reset, waiting for the first start
   // HDR_HI   | expecting header byte {rw, addr[14:8]}
   // HDR_LO   | expecting header byte addr[7:0]
   // WRITE    | every rx byte becomes a register write at ptr
   // RD_ISSUE | issue rd_en at ptr once no discarded read is outstanding
   // RD_WAIT  | waiting for rd_valid or timer terminal count
   // RD_HOLD  | read byte presented on tx, waiting for tx_ready

   typedef enum logic [2:0] {
      IDLE, HDR_HI, HDR_LO, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD
   } state_t;

   localparam logic [15:0] TMR_LOAD = 16'(READ_TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [14:0] ptr;
   logic        rw_flag;
   logic        discard;
   logic [15:0] tmr;

   logic outstanding, hdr_hi_ld, hdr_lo_ld, wr_fire, issue_rd;
   logic rsp_data, rsp_expire, rsp_keep;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = HDR_HI;
      end else begin
         case (state)
            IDLE, WRITE: state_nxt = state;
            HDR_HI:      if (rx_valid) state_nxt = HDR_LO;
            HDR_LO:      if (rx_valid) state_nxt = rw_flag ? RD_ISSUE : WRITE;
            RD_ISSUE:    if (!discard) state_nxt = RD_WAIT;
            RD_WAIT:     if (rsp_data || rsp_expire) state_nxt = RD_HOLD;
            RD_HOLD:     if (tx_ready) state_nxt = RD_ISSUE;
            default:     state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      // a read is in flight either for this frame or for an aborted one
      outstanding = (state == RD_WAIT) || discard;
      hdr_hi_ld   = !start && (state == HDR_HI) && rx_valid;
      hdr_lo_ld   = !start && (state == HDR_LO) && rx_valid;
      wr_fire     = !start && (state == WRITE) && rx_valid;
      issue_rd    = !start && (state == RD_ISSUE) && !discard;
      rsp_data    = outstanding && rd_valid;
      // an aborted read expiring under a write strobe waits one cycle so the pulses never overlap
      rsp_expire  = outstanding && !rd_valid && (tmr == 16'd0) && !wr_fire;
      rsp_keep    = !start && !discard && (state == RD_WAIT) && (rsp_data || rsp_expire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         rw_flag    <= 1'b0;
         discard    <= 1'b0;
         tmr        <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         rd_timeout <= 1'b0;
         tx_valid   <= 1'b0;
         tx_data    <= '0;
      end else begin
         rd_en      <= issue_rd;
         wr_en      <= wr_fire;
         rd_timeout <= rsp_expire;

         if (hdr_hi_ld) begin
            rw_flag     <= rx_data[7];
            ptr[14:8]   <= rx_data[6:0];
         end else if (hdr_lo_ld) begin
            ptr[7:0]    <= rx_data;
         end else if (wr_fire || rsp_keep) begin
            ptr         <= ptr + 15'd1;
         end

         if (wr_fire) begin
            wr_addr <= {1'b0, ptr};
            wr_data <= rx_data;
         end

         // rd_addr changes only here so the responder sees it stable through its wait states
         if (issue_rd) begin
            rd_addr <= {1'b0, ptr};
            tmr     <= TMR_LOAD;
         end else if (outstanding && (tmr != 16'd0)) begin
            tmr     <= tmr - 16'd1;
         end

         if (start && (state == RD_WAIT) && !rsp_data && !rsp_expire)
            discard <= 1'b1;
         else if (discard && (rsp_data || rsp_expire))
            discard <= 1'b0;

         if (start) begin
            tx_valid <= 1'b0;
         end else if (rsp_keep) begin
            tx_valid <= 1'b1;
            tx_data  <= rsp_data ? rd_data : 8'hFF;
         end else if ((state == RD_HOLD) && tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE) || discard;

endmodule

// File: tb/tb_mgmt_bus_initiator.sv
// Bench for mgmt_bus_initiator: directed frames from the test plan plus random frames,
// checked against a transaction-level model of expected writes, read addresses and tx bytes.
module tb_mgmt_bus_initiator;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_ready = 1'b0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic        rd_valid = 1'b0;
   logic [7:0]  rd_data = 8'h00;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        rd_timeout;
   logic        busy;

   mgmt_bus_initiator #(.READ_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_timeout(rd_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // observed bus activity
   logic [23:0] wr_q[$];
   int          wr_cyc_q[$];
   logic [15:0] rd_q[$];
   int          rd_cyc_q[$];
   logic [15:0] hold_addr = 16'h0;
   bit          pend = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (rd_en || wr_en || rd_timeout)
            check("pulse_onehot", 32'($onehot({rd_en, wr_en, rd_timeout})), 32'd1);
         if (wr_en) begin
            wr_q.push_back({wr_addr, wr_data});
            wr_cyc_q.push_back(cyc);
            check("wr_addr_b15", 32'(wr_addr[15]), 32'd0);
         end
         if (rd_en) begin
            rd_q.push_back(rd_addr);
            rd_cyc_q.push_back(cyc);
            hold_addr = rd_addr;
            pend = 1'b1;
            check("rd_addr_b15", 32'(rd_addr[15]), 32'd0);
         end else if (pend) begin
            check("rd_addr_hold", 32'(rd_addr), 32'(hold_addr));
         end
         if (rd_valid || rd_timeout) pend = 1'b0;
      end
   end

   // register-interface responder: per rd_en, pops a delay (-1 = never answer) and a data byte
   int          dly_q[$];
   logic [7:0]  dat_q[$];
   int          due = -1;
   int          resp_d;
   logic [7:0]  cur_dat = 8'h00;

   always @(posedge clk) begin
      #1;
      if (rd_en) begin
         due = -1;
         if (dly_q.size() > 0) begin
            resp_d  = dly_q.pop_front();
            cur_dat = dat_q.pop_front();
            if (resp_d >= 0) due = cyc + resp_d;
         end
      end
      rd_valid = (due >= 0) && (cyc == due);
      rd_data  = rd_valid ? cur_dat : 8'h00;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic clear_logs();
      wr_q.delete();
      wr_cyc_q.delete();
      rd_q.delete();
      rd_cyc_q.delete();
   endtask

   task automatic wait_rd(input int n);
      for (int k = 0; k < 300 && rd_q.size() < n; k++) tick();
      check("rd_issue_count", rd_q.size(), n);
   endtask

   task automatic wait_tx();
      for (int k = 0; k < 300 && !tx_valid; k++) tick();
      check("tx_valid_rise", 32'(tx_valid), 32'd1);
   endtask

   task automatic write_frame(input logic [14:0] a, input int n, input bit gaps);
      logic [23:0] exp_q[$];
      logic [7:0]  b;
      int          addr;
      pulse_start();
      clear_logs();
      send({1'b0, a[14:8]});
      send(a[7:0]);
      for (int i = 0; i < n; i++) begin
         b    = 8'($urandom);
         addr = (int'(a) + i) % 32768;
         exp_q.push_back({16'(addr), b});
         send(b);
         if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(2);
      check("wr_count", wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         check("wr_addr_data", 32'(wr_q[i]), 32'(exp_q[i]));
         if (!gaps && i > 0) check("wr_back_to_back", wr_cyc_q[i] - wr_cyc_q[i-1], 1);
      end
      check("wr_no_rd_en", rd_q.size(), 0);
   endtask

   int         rf_dly[$];
   logic [7:0] rf_dat[$];

   task automatic read_frame(input logic [14:0] a, input int n);
      int         addr;
      bit         exp_to;
      logic [7:0] exp_b;
      int         exp_lat;
      pulse_start();
      clear_logs();
      dly_q = rf_dly;
      dat_q = rf_dat;
      send({1'b1, a[14:8]});
      send(a[7:0]);
      for (int i = 0; i < n; i++) begin
         addr    = (int'(a) + i) % 32768;
         exp_to  = !(rf_dly[i] >= 0 && rf_dly[i] < T);
         exp_b   = exp_to ? 8'hFF : rf_dat[i];
         exp_lat = exp_to ? T : rf_dly[i] + 1;
         wait_rd(i + 1);
         wait_tx();
         if (rd_q.size() > i) begin
            check("rd_addr", 32'(rd_q[i]), 32'(addr));
            check("rsp_latency", cyc - rd_cyc_q[i], exp_lat);
         end
         check("tx_data", 32'(tx_data), 32'(exp_b));
         check("rd_timeout", 32'(rd_timeout), 32'(exp_to));
         idle($urandom_range(0, 3));
         check("no_early_prefetch", rd_q.size(), i + 1);
         check("tx_hold", 32'(tx_valid), 32'd1);
         tx_ready = 1'b1;
         tick();
         tx_ready = 1'b0;
         check("tx_clear", 32'(tx_valid), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int       n;
      logic [14:0] a;

      #3;
      check("reset_outputs", 32'(|{tx_valid, tx_data, rd_en, rd_addr, wr_en, wr_addr,
                                   wr_data, rd_timeout, busy}), 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(2);
      send(8'h00);
      idle(2);
      check("idle_ignores_rx", wr_q.size() + rd_q.size(), 0);
      check("idle_not_busy", 32'(busy), 32'd0);

      write_frame(15'h0048, 2, 1'b0);
      write_frame(15'h7FFF, 2, 1'b0);

      rf_dly = '{5, 5};
      rf_dat = '{8'h12, 8'h34};
      read_frame(15'h0004, 2);

      rf_dly = '{-1, -1};
      rf_dat = '{8'h00, 8'h00};
      read_frame(15'h0100, 2);

      // rd_valid on the terminal-count cycle wins; read address wraps
      rf_dly = '{T - 1, 0};
      rf_dat = '{8'hC3, 8'h3C};
      read_frame(15'h7FFF, 2);

      // abort mid-read: the late response is dropped before the new frame's first read
      pulse_start();
      clear_logs();
      dly_q = '{12, 3};
      dat_q = '{8'h99, 8'h5A};
      send(8'h80);
      send(8'h10);
      wait_rd(1);
      idle(2);
      pulse_start();
      check("abort_busy", 32'(busy), 32'd1);
      send(8'h80);
      send(8'h20);
      wait_tx();
      check("abort_tx_data", 32'(tx_data), 32'h5A);
      check("abort_rd_count", rd_q.size(), 2);
      if (rd_q.size() == 2) begin
         check("abort_first_addr", 32'(rd_q[0]), 32'h0010);
         check("abort_next_addr", 32'(rd_q[1]), 32'h0020);
         check("abort_after_late", 32'(rd_cyc_q[1] > rd_cyc_q[0] + 12), 32'd1);
      end
      check("abort_no_timeout", 32'(rd_timeout), 32'd0);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;

      for (int f = 0; f < 16; f++) begin
         n = $urandom_range(1, 4);
         a = ($urandom_range(0, 3) == 0) ? 15'(32766 + $urandom_range(0, 1))
                                         : 15'($urandom_range(0, 32767));
         if ($urandom_range(0, 1) == 1) begin
            write_frame(a, n, 1'($urandom_range(0, 1)));
         end else begin
            rf_dly.delete();
            rf_dat.delete();
            for (int j = 0; j < n; j++) begin
               rf_dly.push_back(($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, T - 1)));
               rf_dat.push_back(8'($urandom));
            end
            read_frame(a, n);
         end
      end

      // reset while a read byte is held for the host
      pulse_start();
      clear_logs();
      dly_q = '{2};
      dat_q = '{8'h77};
      send(8'h80);
      send(8'h30);
      wait_tx();
      check("pre_reset_tx", 32'(tx_data), 32'h77);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 32'(|{tx_valid, tx_data, rd_en, rd_addr, wr_en, wr_addr,
                                         wr_data, rd_timeout, busy}), 32'd0);
      tick();
      rst_n = 1'b1;
      clear_logs();
      send(8'h00);
      send(8'h40);
      send(8'hAB);
      idle(3);
      check("post_reset_no_strobes", wr_q.size() + rd_q.size(), 0);
      check("post_reset_idle", 32'(busy | tx_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
